reg_file_mp: RTL and testbench

//   Parametrised multi-read-port register file for the 16-bit processor datapath.
//   - Provides NUM_RD asynchronous read ports and one synchronous write port.
//   - Optional write-to-read bypass.
//   - Optional hardwired-zero register 0.
//   - Array has no reset, so it infers distributed RAM. A sequential clear FSM

---
 rtl/proc_pkg.sv | 12 +
 rtl/rf_clear_seq.sv | 66 ++++++
 rtl/reg_file_mp.sv | 77 +++++++
 tb/tb_reg_file_mp.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared datapath definitions: default register-file geometry and clear-FSM states.
package proc_pkg;

    localparam int unsigned RF_DATA_W = 16;
    localparam int unsigned RF_ADDR_W = 4;

    typedef enum logic {
        RF_IDLE,
        RF_CLEAR
    } rf_state_t;

endpackage

// File: rtl/rf_clear_seq.sv
// Sequential clear sweep for the register file: walks every address once,
// asserting clr_we, and holds busy high for the whole sweep.
module rf_clear_seq
    import proc_pkg::*;
#(
    parameter int unsigned ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST = '1;

    rf_state_t         state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic              busy_nxt;

    // State, pointer and busy registers; reset (re)starts the sweep from 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RF_CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            busy  <= busy_nxt;
        end
    end

    // Next-state logic; clr_req is only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        busy_nxt  = busy;
        unique case (state)
            RF_IDLE: begin
                if (clr_req) begin
                    state_nxt = RF_CLEAR;
                    ptr_nxt   = '0;
                    busy_nxt  = 1'b1;
                end
            end
            RF_CLEAR: begin
                ptr_nxt = ptr + 1'b1;
                if (ptr == LAST) begin
                    state_nxt = RF_IDLE;
                    busy_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = RF_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // No array write while reset is held, even though state already reads CLEAR.
    assign clr_we   = (state == RF_CLEAR) && !reset;
    assign clr_addr = ptr;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file: NUM_RD combinational read ports, one
// synchronous write port, optional bypass and hardwired-zero register 0.
// The array has no reset; rf_clear_seq zeroes it after reset or on request.
module reg_file_mp
    import proc_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     clr_req,
    output logic                     busy,
    output logic                     wr_drop
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_zero_skip;
    logic              wr_ok;

    rf_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear (
        .clk      (CLK),
        .reset    (reset),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Writes to r0 with ZERO_REG are silently ignored (not a drop).
    assign wr_zero_skip = (ZERO_REG != 0) && (wr_addr == '0);
    assign wr_ok        = wr_en && !busy && !clr_req && !reset && !wr_zero_skip;

    // Array write: clear sweep and user write are exclusive since wr_ok needs !busy.
    always_ff @(posedge CLK) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Flag a write discarded because of a sweep in progress or starting.
    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= wr_en && (busy || clr_req);
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = rd_addr[i*ADDR_W +: ADDR_W];
        // Priority: busy, hardwired zero, bypass, array.
        assign rd_data[i*DATA_W +: DATA_W] =
            busy                                ? '0      :
            ((ZERO_REG != 0) && (ra == '0))     ? '0      :
            ((BYPASS != 0) && wr_ok && (wr_addr == ra)) ? wr_data :
                                                  mem[ra];
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a BYPASS=1/ZERO_REG=1 instance and a
// BYPASS=0/ZERO_REG=0 instance share all inputs.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data, rd_data_alt;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        clr_req;
    logic        busy, busy_alt;
    logic        wr_drop, wr_drop_alt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_file_mp #(
        .DATA_W   (16),
        .ADDR_W   (4),
        .NUM_RD   (2),
        .BYPASS   (1),
        .ZERO_REG (1)
    ) dut (
        .CLK     (clk),
        .reset   (reset),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .clr_req (clr_req),
        .busy    (busy),
        .wr_drop (wr_drop)
    );

    reg_file_mp #(
        .DATA_W   (16),
        .ADDR_W   (4),
        .NUM_RD   (2),
        .BYPASS   (0),
        .ZERO_REG (0)
    ) dut_alt (
        .CLK     (clk),
        .reset   (reset),
        .rd_addr (rd_addr),
        .rd_data (rd_data_alt),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .clr_req (clr_req),
        .busy    (busy_alt),
        .wr_drop (wr_drop_alt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts sampled cycles with busy high (bounded), noting any nonzero read.
    task automatic count_busy(output int n, output bit rd_nz);
        n = 0;
        rd_nz = 1'b0;
        while (busy && n < 40) begin
            if (rd_data != '0 || rd_data_alt != '0) rd_nz = 1'b1;
            n++;
            tick();
        end
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 16; i++) begin
            rd_addr = {4'(15 - i), 4'(i)};
            #1;
            chk(tag, rd_data, 32'h0);
            chk({tag, "_alt"}, rd_data_alt, 32'h0);
        end
    endtask

    initial begin
        int  n;
        bit  nz;

        reset   = 1'b1;
        rd_addr = {4'd5, 4'd10};
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        clr_req = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_busy", {31'b0, busy}, 32'h1);
        chk("rst_busy_alt", {31'b0, busy_alt}, 32'h1);
        chk("rst_drop", {31'b0, wr_drop}, 32'h0);
        chk("rst_rd", rd_data, 32'h0);

        // Release: busy for exactly 16 cycles, reads 0 throughout
        reset = 1'b0;
        #1;
        count_busy(n, nz);
        chk("init_busy_len", n, 32'd16);
        chk("init_rd_zero_busy", {31'b0, nz}, 32'h0);
        chk("init_busy_alt", {31'b0, busy_alt}, 32'h0);
        check_all_zero("init_clear");

        // Basic writes and dual-port read
        write_reg(4'd5, 16'hBEEF);
        write_reg(4'd10, 16'h1234);
        rd_addr = {4'd5, 4'd10};
        #1;
        chk("rd_5_10", rd_data, {16'hBEEF, 16'h1234});
        chk("rd_5_10_alt", rd_data_alt, {16'hBEEF, 16'h1234});
        chk("no_drop", {31'b0, wr_drop}, 32'h0);
        rd_addr = {4'd10, 4'd10};
        #1;
        chk("rd_same_addr", rd_data, {16'h1234, 16'h1234});

        // Bypass vs. no bypass
        rd_addr = {4'd5, 4'd7};
        wr_en   = 1'b1;
        wr_addr = 4'd7;
        wr_data = 16'hA5A5;
        #1;
        chk("bypass_on", rd_data, {16'hBEEF, 16'hA5A5});
        chk("bypass_off", rd_data_alt, {16'hBEEF, 16'h0000});
        tick();
        wr_en = 1'b0;
        #1;
        chk("bypass_off_next", rd_data_alt[15:0], 32'hA5A5);
        chk("bypass_on_next", rd_data[15:0], 32'hA5A5);

        // Zero register; zero takes priority over bypass
        rd_addr = {4'd7, 4'd0};
        wr_en   = 1'b1;
        wr_addr = 4'd0;
        wr_data = 16'hFFFF;
        #1;
        chk("zero_over_bypass", rd_data[15:0], 32'h0);
        tick();
        wr_en = 1'b0;
        #1;
        chk("zero_reg_rd", rd_data[15:0], 32'h0);
        chk("zero_reg_off_rd", rd_data_alt[15:0], 32'hFFFF);
        chk("zero_reg_no_drop", {31'b0, wr_drop}, 32'h0);
        chk("zero_reg_off_no_drop", {31'b0, wr_drop_alt}, 32'h0);

        // clr_req together with a write: write dropped, sweep runs 16 cycles
        wr_en   = 1'b1;
        wr_addr = 4'd3;
        wr_data = 16'h0042;
        clr_req = 1'b1;
        #1;
        chk("pre_clr_drop", {31'b0, wr_drop}, 32'h0);
        chk("pre_clr_bypass_blocked", {16'h0, rd_data_alt[15:0]}, 32'hFFFF);
        tick();
        // sweep edge count so far: 0; clr_req kept high to show it is ignored
        wr_addr = 4'd4;
        wr_data = 16'h1111;
        #1;
        chk("clr_drop", {31'b0, wr_drop}, 32'h1);
        chk("clr_busy", {31'b0, busy}, 32'h1);
        tick();
        wr_en = 1'b0;
        #1;
        chk("busy_drop", {31'b0, wr_drop}, 32'h1);
        chk("busy_drop_alt", {31'b0, wr_drop_alt}, 32'h1);
        tick();
        clr_req = 1'b0;
        #1;
        chk("drop_clears", {31'b0, wr_drop}, 32'h0);
        count_busy(n, nz);
        chk("clr_busy_remaining", n, 32'd14);
        chk("clr_rd_zero_busy", {31'b0, nz}, 32'h0);
        rd_addr = {4'd4, 4'd3};
        #1;
        chk("r3_r4_cleared", rd_data, 32'h0);
        chk("r3_r4_cleared_alt", rd_data_alt, 32'h0);
        check_all_zero("clr_sweep");

        // Reset mid-sweep restarts a full 16-cycle sweep
        write_reg(4'd15, 16'h7777);
        write_reg(4'd8, 16'h0001);
        rd_addr = {4'd15, 4'd8};
        #1;
        chk("pre_sweep_vals", rd_data, {16'h7777, 16'h0001});
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (8) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", {31'b0, busy}, 32'h1);
        count_busy(n, nz);
        chk("mid_rst_busy_len", n, 32'd16);
        chk("mid_rst_rd_zero_busy", {31'b0, nz}, 32'h0);
        check_all_zero("mid_rst_clear");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1);
    end

endmodule
